fifo_wconv_ctrl: RTL and testbench

- Pointer and flag controller for the 2:1 width-converting FIFO register file: 16-bit writes land in two consecutive byte slots, and reads return 1 byte.
- Owns the write/read pointers, write enable, occupancy, full/empty and almost-full flags.
- Sits between the producer (16-bit pushes) and consumer (byte pops) and drives the register file's w_en, w_addr and r_addr.

---
 rtl/fifo_wconv_pkg.sv | 12 +
 rtl/fifo_wconv_occ.sv | 57 +++++
 rtl/fifo_wconv_ctrl.sv | 94 +++++++++
 tb/tb_fifo_wconv_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wconv_pkg.sv
// Shared constants and helpers for the 2:1 width-converting FIFO controller.
// Optional sticky error flags are enabled with FIFO_WCONV_ERR_FLAGS_EN.
package fifo_wconv_pkg;

  localparam int unsigned BYTES_PER_WORD = 2;

  // Occupancy counter width: must hold 0..2**aw inclusive.
  function automatic int unsigned occ_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_wconv_occ.sv
// Byte-occupancy counter and registered full/empty/almost_full flags.
// Flags are derived from the next occupancy, so they line up with the new count.
module fifo_wconv_occ
  import fifo_wconv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push_ok,
  input  logic                  i_pop_ok,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full
);

  localparam int unsigned CW    = occ_width(ADDR_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [CW-1:0] FULL_THR = CW'(DEPTH - BYTES_PER_WORD);
  localparam logic [CW-1:0] AF_THR   = CW'(AF_LEVEL);

  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_almost_full;
  logic [CW-1:0] w_count_next;

  // A push is only accepted with at least two free slots, so this never exceeds DEPTH.
  always_comb begin
    w_count_next = r_count;
    if (i_push_ok) w_count_next = w_count_next + CW'(BYTES_PER_WORD);
    if (i_pop_ok)  w_count_next = w_count_next - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count       <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_empty       <= (w_count_next == '0);
      r_full        <= (w_count_next > FULL_THR);
      r_almost_full <= (w_count_next >= AF_THR);
    end
  end

  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_almost_full;

endmodule

// File: rtl/fifo_wconv_ctrl.sv
// Pointer/flag controller for a FIFO with 16-bit writes and 8-bit reads.
// Define FIFO_WCONV_ERR_FLAGS_EN for sticky overflow/underflow flags.
module fifo_wconv_ctrl
  import fifo_wconv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  ptr_t r_wptr;
  ptr_t r_rptr;
  logic w_push_ok;
  logic w_pop_ok;

  assign w_push_ok = wr & ~full;
  assign w_pop_ok  = rd & ~empty;

  // wptr steps by a whole word and stays even, so w_addr+1 never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + ptr_t'(BYTES_PER_WORD);
      if (w_pop_ok)  r_rptr <= r_rptr + ptr_t'(1);
    end
  end

  assign w_en   = w_push_ok;
  assign w_addr = r_wptr[ADDR_WIDTH-1:0];
  assign r_addr = r_rptr[ADDR_WIDTH-1:0];

  // Occupancy drives the flags, so the pointer wrap bits are informational only.
  logic w_unused_wrap;
  assign w_unused_wrap = r_wptr[ADDR_WIDTH] ^ r_rptr[ADDR_WIDTH];

  fifo_wconv_occ #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL)
  ) u_occ (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_push_ok     (w_push_ok),
    .i_pop_ok      (w_pop_ok),
    .o_count       (count),
    .o_empty       (empty),
    .o_full        (full),
    .o_almost_full (almost_full)
  );

`ifdef FIFO_WCONV_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A set condition wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & full)    r_overflow  <= 1'b1;
      else if (err_clr) r_overflow  <= 1'b0;
      if (rd & empty)   r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wconv_ctrl.sv
// Self-checking bench: byte-queue model of the width-converting FIFO plus directed vectors.
module tb_fifo_wconv_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr, rd, err_clr;
  logic [15:0]   wdata;
  logic          w_en, full, empty, almost_full, overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  int n_chk = 0;
  int n_err = 0;

  fifo_wconv_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AFL)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .w_en(w_en),
    .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Register file stand-in: low byte at the even slot, high byte above it.
  logic [7:0] mem [DEPTH];
  always @(posedge clk) begin
    if (w_en) begin
      mem[w_addr]         <= wdata[7:0];
      mem[w_addr + 3'd1]  <= wdata[15:8];
    end
  end

  // Behavioural model: a queue of stored bytes and free-running byte pointers.
  logic [7:0] q[$];
  int  mw = 0, mr = 0;
  bit  movf = 0, mudf = 0;

  function automatic bit m_full();  return q.size() > DEPTH - 2; endfunction
  function automatic bit m_empty(); return q.size() == 0;        endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete(); mw = 0; mr = 0; movf = 0; mudf = 0;
    end else begin
      bit fl, em;
      fl = m_full(); em = m_empty();
`ifdef FIFO_WCONV_ERR_FLAGS_EN
      if (wr && fl) movf = 1; else if (err_clr) movf = 0;
      if (rd && em) mudf = 1; else if (err_clr) mudf = 0;
`endif
      if (rd && !em) begin void'(q.pop_front()); mr++; end
      if (wr && !fl) begin q.push_back(wdata[7:0]); q.push_back(wdata[15:8]); mw += 2; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of registered state and head-of-queue data.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("count",       32'(count),       32'(q.size()));
      chk("empty",       32'(empty),       32'(m_empty()));
      chk("full",        32'(full),        32'(m_full()));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
      chk("w_addr",      32'(w_addr),      32'(mw % DEPTH));
      chk("r_addr",      32'(r_addr),      32'(mr % DEPTH));
      chk("overflow",    32'(overflow),    32'(movf));
      chk("underflow",   32'(underflow),   32'(mudf));
      if (q.size() != 0) chk("r_data", 32'(mem[r_addr]), 32'(q[0]));
    end
  end

  // One cycle of stimulus; w_en is checked combinationally before the edge.
  task automatic step(input bit w, input bit r, input bit c, input logic [15:0] d);
    wr = w; rd = r; err_clr = c; wdata = d;
    #1;
    chk("w_en", 32'(w_en), 32'(w && !m_full()));
    @(posedge clk); #1;
    wr = 0; rd = 0; err_clr = 0;
  endtask

  int ra, wa;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; wr = 0; rd = 0; err_clr = 0; wdata = '0;
    #12 reset_n = 1;
    @(posedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_w_en",  32'(w_en),  0);

    // Byte order of one word
    step(1, 0, 0, 16'hBBAA);
    chk("p1_count", 32'(count), 2);
    chk("p1_lo",    32'(mem[r_addr]), 32'h0AA);
    step(0, 1, 0, 0);
    chk("p1_count1", 32'(count), 1);
    chk("p1_hi",     32'(mem[r_addr]), 32'h0BB);
    step(0, 1, 0, 0);
    chk("p1_count0", 32'(count), 0);
    chk("p1_empty",  32'(empty), 1);

    // Fill to full
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h1100 + 16'(i));
    chk("f3_count", 32'(count), 6);
    chk("f3_af",    32'(almost_full), 1);
    chk("f3_full",  32'(full), 0);
    step(1, 0, 0, 16'h2233);
    chk("f4_count", 32'(count), 8);
    chk("f4_full",  32'(full), 1);
    step(1, 0, 0, 16'hDEAD);
    chk("f5_count", 32'(count), 8);

    // One free byte: still full, simultaneous push rejected
    step(0, 1, 0, 0);
    chk("s7_count", 32'(count), 7);
    chk("s7_full",  32'(full), 1);
    step(1, 1, 0, 16'hBEEF);
    chk("s6_count", 32'(count), 6);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("drain0", 32'(count), 0);

    // Simultaneous push/pop from count 3
    step(1, 0, 0, 16'h5501);
    step(1, 0, 0, 16'h5502);
    step(0, 1, 0, 0);
    chk("c3_count", 32'(count), 3);
    ra = mr; wa = mw;
    step(1, 1, 0, 16'h5503);
    chk("c4_count", 32'(count), 4);
    chk("c4_raddr", 32'(r_addr), 32'((ra + 1) % DEPTH));
    chk("c4_waddr", 32'(w_addr), 32'((wa + 2) % DEPTH));

    // Stream 20 words across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, {8'(2 * i + 1), 8'(2 * i) ^ 8'h80});
      step(0, 1, 0, 0);
    end
    chk("stream_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("stream_empty", 32'(empty), 1);

    // Error flags
    step(0, 1, 0, 0);
`ifdef FIFO_WCONV_ERR_FLAGS_EN
    chk("udf_set", 32'(underflow), 1);
    step(0, 0, 0, 0);
    chk("udf_sticky", 32'(underflow), 1);
    step(0, 0, 1, 0);
    chk("udf_clr", 32'(underflow), 0);
`else
    chk("udf_off", 32'(underflow), 0);
`endif
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'hA000 + 16'(i));
    step(1, 0, 0, 16'hFFFF);
`ifdef FIFO_WCONV_ERR_FLAGS_EN
    chk("ovf_set", 32'(overflow), 1);
    step(1, 0, 1, 16'hFFFF);
    chk("ovf_set_wins", 32'(overflow), 1);
    step(0, 0, 1, 0);
    chk("ovf_clr", 32'(overflow), 0);
`else
    chk("ovf_off", 32'(overflow), 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 16'h1234);
`endif

    // Asynchronous reset mid-stream at count 5
    while (q.size() > 5) step(0, 1, 0, 0);
    chk("pre_rst_count", 32'(count), 5);
    #2 reset_n = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full",  32'(full), 0);
    @(negedge clk); #1 reset_n = 1;
    @(posedge clk); #1;
    step(1, 0, 0, 16'h7766);
    chk("post_rst_count", 32'(count), 2);
    chk("post_rst_lo",    32'(mem[r_addr]), 32'h066);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
